// File: rtl/cdc_fifo_drain_packer_if.sv
// Read-side bus of the CDC FIFO drain packer: FIFO show-ahead port, flush request,
// packed valid/ready output and delivered-beat counter.
interface cdc_fifo_drain_packer_if #(
    parameter int DATA_WIDTH = 4,
    parameter int PACK       = 2,
    parameter int CNT_WIDTH  = 16
);
    logic                         fifo_empty;
    logic [DATA_WIDTH-1:0]        fifo_data;
    logic                         fifo_increment;
    logic                         flush;
    logic [DATA_WIDTH*PACK-1:0]   out_data;
    logic [$clog2(PACK+1)-1:0]    out_lanes;
    logic                         out_valid;
    logic                         out_ready;
    logic [CNT_WIDTH-1:0]         beat_count;

    // master is the packer itself; slave is the FIFO/downstream side
    modport master (
        input  fifo_empty, fifo_data, flush, out_ready,
        output fifo_increment, out_data, out_lanes, out_valid, beat_count
    );

    modport slave (
        output fifo_empty, fifo_data, flush, out_ready,
        input  fifo_increment, out_data, out_lanes, out_valid, beat_count
    );
endinterface

// File: rtl/cdc_fifo_drain_packer.sv
// Pops FIFO entries in the read clock domain and packs PACK of them into one wide
// registered valid/ready beat; a flush request emits a partially filled beat.
module cdc_fifo_drain_packer #(
    parameter int DATA_WIDTH = 4,
    parameter int PACK       = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cdc_fifo_drain_packer_if.master bus
);
    localparam int LANES_W = $clog2(PACK + 1);
    localparam int IDX_W   = $clog2(PACK);
    localparam int BEAT_W  = DATA_WIDTH * PACK;

    logic [IDX_W-1:0]  cnt;
    logic [BEAT_W-1:0] acc;
    logic [BEAT_W-1:0] acc_filled;
    logic              flush_pending;
    logic              slot_free;
    logic              last_lane;
    logic              pop;
    logic              handshake;
    logic              flush_emit;
    logic              load;

    always_comb begin
        slot_free  = !bus.out_valid || bus.out_ready;
        last_lane  = (cnt == IDX_W'(PACK - 1));
        // the last lane may only be popped when the output slot can take the beat
        pop        = rst_n && !bus.fifo_empty && !flush_pending && !(last_lane && !slot_free);
        handshake  = bus.out_valid && bus.out_ready;
        flush_emit = flush_pending && (cnt != '0) && slot_free;
        load       = (pop && last_lane) || flush_emit;
        acc_filled = acc;
        acc_filled[cnt*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_data;
    end

    assign bus.fifo_increment = pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            acc            <= '0;
            flush_pending  <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_data   <= '0;
            bus.out_lanes  <= '0;
            bus.beat_count <= '0;
        end else begin
            if (load) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= flush_emit ? acc : acc_filled;
                bus.out_lanes <= flush_emit ? LANES_W'(cnt) : LANES_W'(PACK);
            end else if (handshake) begin
                bus.out_valid <= 1'b0;
            end

            if (load) begin
                cnt <= '0;
                acc <= '0;
            end else if (pop) begin
                cnt <= cnt + IDX_W'(1);
                acc <= acc_filled;
            end

            if (flush_pending) begin
                if (cnt == '0 || slot_free)
                    flush_pending <= 1'b0;
            end else if (bus.flush) begin
                flush_pending <= 1'b1;
            end

            if (handshake && bus.beat_count != '1)
                bus.beat_count <= bus.beat_count + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_cdc_fifo_drain_packer.sv
// Directed bench for cdc_fifo_drain_packer: PACK=2 of 4-bit entries, a 4-bit
// beat counter so saturation is reachable, FIFO and downstream modelled here.
module tb_cdc_fifo_drain_packer;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    cdc_fifo_drain_packer_if #(.DATA_WIDTH(4), .PACK(2), .CNT_WIDTH(4)) bus ();

    cdc_fifo_drain_packer #(.DATA_WIDTH(4), .PACK(2), .CNT_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [3:0] mem [0:63];
    logic [6:0] wr_ptr = '0;
    logic [6:0] rd_ptr = '0;

    assign bus.fifo_empty = (rd_ptr == wr_ptr);
    assign bus.fifo_data  = mem[rd_ptr[5:0]];

    always @(posedge clk)
        if (bus.fifo_increment) rd_ptr <= rd_ptr + 7'd1;

    logic [7:0] log_data  [0:31];
    logic [1:0] log_lanes [0:31];
    int         nbeats = 0;

    always @(posedge clk)
        if (rst_n && bus.out_valid && bus.out_ready && nbeats < 32) begin
            log_data[nbeats]  <= bus.out_data;
            log_lanes[nbeats] <= bus.out_lanes;
            nbeats            <= nbeats + 1;
        end

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] v);
        mem[wr_ptr[5:0]] = v;
        wr_ptr = wr_ptr + 7'd1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = '0;

        // reset with FIFO holding data
        push(4'h3);
        push(4'hA);
        repeat (3) step();
        check("rst_incr",   bus.fifo_increment, 0);
        check("rst_valid",  bus.out_valid, 0);
        check("rst_count",  bus.beat_count, 0);
        check("rst_lanes",  bus.out_lanes, 0);
        check("rst_data",   bus.out_data, 0);
        check("rst_nopop",  rd_ptr, 0);

        // two pops, beat A3 one clock after the last pop
        rst_n = 1'b1;
        #1;
        check("pop0_incr", bus.fifo_increment, 1);
        step();
        check("pop1_incr", bus.fifo_increment, 1);
        check("pop1_valid", bus.out_valid, 0);
        step();
        check("beat_a3_valid", bus.out_valid, 1);
        check("beat_a3_data",  bus.out_data, 8'hA3);
        check("beat_a3_lanes", bus.out_lanes, 2);
        check("beat_a3_empty_incr", bus.fifo_increment, 0);
        step();
        check("beat_a3_count", bus.beat_count, 1);
        check("beat_a3_drop",  bus.out_valid, 0);

        // backpressure with six entries
        bus.out_ready = 1'b0;
        for (int v = 1; v <= 6; v++) push(4'(v));
        repeat (5) step();
        check("bp_held_valid", bus.out_valid, 1);
        check("bp_held_data",  bus.out_data, 8'h21);
        check("bp_blocked",    bus.fifo_increment, 0);
        check("bp_pops",       rd_ptr, 5);
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_incr", bus.fifo_increment, 1);
        for (int i = 0; i < 20 && nbeats < 4; i++) step();
        repeat (3) step();
        check("bp_nbeats", nbeats, 4);
        check("bp_beat1",  log_data[1], 8'h21);
        check("bp_beat2",  log_data[2], 8'h43);
        check("bp_beat3",  log_data[3], 8'h65);
        check("bp_lanes3", log_lanes[3], 2);
        check("bp_count",  bus.beat_count, 4);

        // flush of a single entry, then flush with nothing accumulated
        push(4'h7);
        repeat (2) step();
        check("fl_wait_valid", bus.out_valid, 0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("fl_pending_valid", bus.out_valid, 0);
        step();
        check("fl_valid", bus.out_valid, 1);
        check("fl_data",  bus.out_data, 8'h07);
        check("fl_lanes", bus.out_lanes, 1);
        step();
        check("fl_nbeats", nbeats, 5);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        step();
        check("fl_empty_nobeat", nbeats, 5);
        check("fl_empty_valid",  bus.out_valid, 0);
        push(4'h9);
        #1;
        check("fl_cleared_incr", bus.fifo_increment, 1);
        step();

        // flush coinciding with a pop while the output slot is stalled
        bus.out_ready = 1'b0;
        push(4'hB);
        push(4'hC);
        #1;
        step();
        check("f5_beat_b9", bus.out_data, 8'hB9);
        check("f5_pop_c",   bus.fifo_increment, 1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        push(4'hD);
        #1;
        check("f5_blocked", bus.fifo_increment, 0);
        repeat (2) step();
        check("f5_hold_valid", bus.out_valid, 1);
        check("f5_hold_data",  bus.out_data, 8'hB9);
        check("f5_still_blocked", bus.fifo_increment, 0);
        bus.out_ready = 1'b1;
        #1;
        check("f5_pending_block", bus.fifo_increment, 0);
        step();
        check("f5_part_data",  bus.out_data, 8'h0C);
        check("f5_part_lanes", bus.out_lanes, 1);
        check("f5_part_valid", bus.out_valid, 1);
        check("f5_resume_incr", bus.fifo_increment, 1);
        step();
        check("f5_log_b9",   log_data[5], 8'hB9);
        check("f5_log_0c",   log_data[6], 8'h0C);
        check("f5_log_lane", log_lanes[6], 1);
        check("f5_count",    bus.beat_count, 7);

        // beat counter saturation (4-bit counter)
        for (int v = 1; v <= 15; v++) push(4'(v));
        for (int i = 0; i < 40 && nbeats < 15; i++) step();
        repeat (2) step();
        check("sat_nbeats", nbeats, 15);
        check("sat_first",  log_data[7], 8'h1D);
        check("sat_last",   log_data[14], 8'hFE);
        check("sat_max",    bus.beat_count, 15);
        push(4'h1);
        push(4'h2);
        for (int i = 0; i < 10 && nbeats < 16; i++) step();
        step();
        check("sat_more_nbeats", nbeats, 16);
        check("sat_hold", bus.beat_count, 15);

        // reset mid-beat with a stalled beat and a half-filled accumulator
        bus.out_ready = 1'b0;
        push(4'h3);
        push(4'h4);
        push(4'h5);
        repeat (4) step();
        check("mid_valid_before", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_count", bus.beat_count, 0);
        check("mid_rst_incr",  bus.fifo_increment, 0);
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        push(4'h6);
        push(4'h7);
        for (int i = 0; i < 10 && nbeats < 17; i++) step();
        check("post_rst_nbeats", nbeats, 17);
        check("post_rst_data",   log_data[16], 8'h76);
        check("post_rst_lanes",  log_lanes[16], 2);
        check("post_rst_count",  bus.beat_count, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
